// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Two-stage valid/ready ALU issue pipeline. S1 decodes and drives
//               an external ALU; S2 holds the writeback result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [1:0]  alu_op_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7_b5_i,
    input  logic [63:0] rs1_val_i,
    input  logic [63:0] rs2_val_i,
    input  logic [63:0] imm_i,
    input  logic [4:0]  rd_i,
    output logic [3:0]  ctrl_signal_o,
    output logic [63:0] op1_o,
    output logic [63:0] op2_o,
    input  logic [63:0] alu_result_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] result_o,
    output logic [4:0]  rd_o,
    output logic        illegal_o
);

    localparam logic [3:0] c_AND = 4'b0000;
    localparam logic [3:0] c_OR  = 4'b0001;
    localparam logic [3:0] c_ADD = 4'b0010;
    localparam logic [3:0] c_SUB = 4'b0110;

    logic        r_s1_valid;
    logic [3:0]  r_s1_ctrl;
    logic [63:0] r_s1_op1;
    logic [63:0] r_s1_op2;
    logic [4:0]  r_s1_rd;
    logic        r_s1_illegal;

    logic        r_s2_valid;
    logic [63:0] r_s2_result;
    logic [4:0]  r_s2_rd;
    logic        r_s2_illegal;

    logic        w_s1_adv;
    logic        w_in_xfer;
    logic [3:0]  w_ctrl;
    logic        w_illegal;
    logic [63:0] w_op2;

    assign w_s1_adv   = r_s1_valid & (~r_s2_valid | out_ready_i);
    assign in_ready_o = ~r_s1_valid | w_s1_adv;
    assign w_in_xfer  = in_valid_i & in_ready_o;

    // Branch and R-type use rs2; load/store and I-type use the immediate.
    assign w_op2 = (alu_op_i[1] ^ alu_op_i[0]) ? rs2_val_i : imm_i;

    always_comb begin
        w_ctrl    = c_ADD;
        w_illegal = 1'b0;
        case (alu_op_i)
            2'b00: w_ctrl = c_ADD;
            2'b01: w_ctrl = c_SUB;
            2'b10: begin
                case (funct3_i)
                    3'b000:  w_ctrl = funct7_b5_i ? c_SUB : c_ADD;
                    3'b111:  w_ctrl = c_AND;
                    3'b110:  w_ctrl = c_OR;
                    default: w_illegal = 1'b1;
                endcase
            end
            default: begin
                case (funct3_i)
                    3'b000:  w_ctrl = c_ADD;
                    3'b111:  w_ctrl = c_AND;
                    3'b110:  w_ctrl = c_OR;
                    default: w_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // Operand registers keep their last values when S1 drains.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid   <= 1'b0;
            r_s1_ctrl    <= 4'b0000;
            r_s1_op1     <= 64'd0;
            r_s1_op2     <= 64'd0;
            r_s1_rd      <= 5'd0;
            r_s1_illegal <= 1'b0;
        end else if (w_in_xfer) begin
            r_s1_valid   <= 1'b1;
            r_s1_ctrl    <= w_ctrl;
            r_s1_op1     <= rs1_val_i;
            r_s1_op2     <= w_op2;
            r_s1_rd      <= rd_i;
            r_s1_illegal <= w_illegal;
        end else if (w_s1_adv) begin
            r_s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s2_valid   <= 1'b0;
            r_s2_result  <= 64'd0;
            r_s2_rd      <= 5'd0;
            r_s2_illegal <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid   <= 1'b1;
            r_s2_result  <= r_s1_illegal ? 64'd0 : alu_result_i;
            r_s2_rd      <= r_s1_rd;
            r_s2_illegal <= r_s1_illegal;
        end else if (out_ready_i) begin
            r_s2_valid   <= 1'b0;
        end
    end

    assign ctrl_signal_o = r_s1_ctrl;
    assign op1_o         = r_s1_op1;
    assign op2_o         = r_s1_op2;
    assign out_valid_o   = r_s2_valid;
    assign result_o      = r_s2_result;
    assign rd_o          = r_s2_rd;
    assign illegal_o     = r_s2_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue
// Description : Directed scoreboard bench for alu_issue with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [4:0]  rd_out;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    alu_issue dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .funct7_b5_i   (f7b5),
        .rs1_val_i     (rs1),
        .rs2_val_i     (rs2),
        .imm_i         (imm),
        .rd_i          (rd),
        .ctrl_signal_o (ctrl),
        .op1_o         (op1),
        .op2_o         (op2),
        .alu_result_i  (alu_result),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .result_o      (result),
        .rd_o          (rd_out),
        .illegal_o     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_result = 64'hDEAD_BEEF_DEAD_BEEF;
        case (ctrl)
            4'b0000: alu_result = op1 & op2;
            4'b0001: alu_result = op1 | op2;
            4'b0010: alu_result = op1 + op2;
            4'b0110: alu_result = op1 - op2;
            default: alu_result = 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    end

    function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] im, input logic [4:0] d);
        exp_t e;
        logic [63:0] o2;
        e.rd  = d;
        e.ill = 1'b0;
        e.res = 64'd0;
        o2 = (op == 2'b01 || op == 2'b10) ? b : im;
        if (op == 2'b00)                          e.res = a + o2;
        else if (op == 2'b01)                     e.res = a - o2;
        else if (f3 == 3'b000 && op == 2'b10 && f7) e.res = a - o2;
        else if (f3 == 3'b000)                    e.res = a + o2;
        else if (f3 == 3'b111)                    e.res = a & o2;
        else if (f3 == 3'b110)                    e.res = a | o2;
        else                                      e.ill = 1'b1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Holds in_valid high after acceptance so callers can issue back-to-back.
    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] im, input logic [4:0] d);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        alu_op = op; funct3 = f3; f7b5 = f7;
        rs1 = a; rs2 = b; imm = im; rd = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(op, f3, f7, a, b, im, d));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed in_ready=0 expected acceptance within 50 cycles");
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_output: observed result %h expected no output", result);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_result", result, e.res);
                chk("sb_rd", {59'd0, rd_out}, {59'd0, e.rd});
                chk("sb_illegal", {63'd0, illegal}, {63'd0, e.ill});
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; funct3 = 3'b000; f7b5 = 1'b0;
        rs1 = 64'd0; rs2 = 64'd0; imm = 64'd0; rd = 5'd0;
        cycles(2);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ctrl", {60'd0, ctrl}, 64'd0);
        chk("rst_result", result, 64'd0);
        rst = 1'b0;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // R-type ADD latency
        send(2'b10, 3'b000, 1'b0, 64'd5, 64'd7, 64'd0, 5'd3);
        in_valid = 1'b0;
        chk("add_ctrl", {60'd0, ctrl}, 64'h2);
        chk("add_op1", op1, 64'd5);
        chk("add_op2", op2, 64'd7);
        chk("add_lat1_valid", {63'd0, out_valid}, 64'd0);
        cycles(1);
        chk("add_lat2_valid", {63'd0, out_valid}, 64'd1);
        chk("add_result", result, 64'd12);
        chk("add_rd", {59'd0, rd_out}, 64'd3);
        cycles(1);

        // Back-to-back SUB then I-type OR
        send(2'b01, 3'b000, 1'b0, 64'd3, 64'd10, 64'd0, 5'd4);
        send(2'b11, 3'b110, 1'b0, 64'hF0, 64'd0, 64'h0F, 5'd5);
        in_valid = 1'b0;
        chk("b2b_sub", result, 64'hFFFF_FFFF_FFFF_FFF9);
        cycles(1);
        chk("b2b_or_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_or", result, 64'hFF);
        cycles(1);

        // Decode coverage including illegal encodings
        send(2'b10, 3'b000, 1'b1, 64'd100, 64'd1, 64'd55, 5'd9);
        send(2'b11, 3'b000, 1'b1, 64'd1, 64'd77, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10);
        send(2'b00, 3'b101, 1'b1, 64'h1000, 64'hBAD, 64'd8, 5'd11);
        send(2'b01, 3'b111, 1'b0, 64'd20, 64'd5, 64'd99, 5'd12);
        send(2'b10, 3'b111, 1'b1, 64'hF0F0, 64'h3C3C, 64'd0, 5'd13);
        send(2'b10, 3'b001, 1'b0, 64'd8, 64'd9, 64'd0, 5'd14);
        chk("illegal_ctrl", {60'd0, ctrl}, 64'h2);
        send(2'b11, 3'b010, 1'b0, 64'd8, 64'd9, 64'd3, 5'd15);
        in_valid = 1'b0;
        cycles(4);

        // Back-pressure: stall with both stages full
        out_ready = 1'b0;
        send(2'b11, 3'b111, 1'b0, 64'hFF00, 64'd0, 64'h0F0F, 5'd6);
        send(2'b10, 3'b110, 1'b0, 64'd1, 64'd2, 64'd0, 5'd7);
        in_valid = 1'b1;
        alu_op = 2'b01; rs1 = 64'd50; rs2 = 64'd8; rd = 5'd8;
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_result", result, 64'h0F00);
            chk("stall_s1_op1", op1, 64'd1);
            cycles(1);
        end
        out_ready = 1'b1;
        send(2'b01, 3'b000, 1'b0, 64'd50, 64'd8, 64'd0, 5'd8);
        in_valid = 1'b0;
        cycles(5);

        // Reset with both stages full
        out_ready = 1'b0;
        send(2'b10, 3'b000, 1'b0, 64'd11, 64'd22, 64'd0, 5'd20);
        send(2'b10, 3'b111, 1'b0, 64'd11, 64'd22, 64'd0, 5'd21);
        in_valid = 1'b0;
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        cycles(1);
        sb.delete();
        chk("mrst_valid", {63'd0, out_valid}, 64'd0);
        chk("mrst_ctrl", {60'd0, ctrl}, 64'd0);
        chk("mrst_op1", op1, 64'd0);
        chk("mrst_op2", op2, 64'd0);
        chk("mrst_result", result, 64'd0);
        chk("mrst_rd", {59'd0, rd_out}, 64'd0);
        chk("mrst_illegal", {63'd0, illegal}, 64'd0);
        chk("mrst_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_no_valid", {63'd0, out_valid}, 64'd0);
            cycles(1);
        end

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 rst_i  input  1  reset, synchronous, active-high.
REQ-003 in_valid_i  input  1  upstream operation valid.
REQ-004 in_ready_o  output  1  block accepts the operation this cycle.
REQ-005 alu_op_i  input  2  class: 00 load/store, 01 branch, 10 R-type, 11 I-type.
REQ-006 funct3_i  input  3  instruction funct3.
REQ-007 funct7_b5_i  input  1  instruction funct7 bit 5.
REQ-008 rs1_val_i, rs2_val_i, imm_i  input  64 each  source operands and sign-extended immediate.
REQ-009 rd_i  input  5  destination register tag.
REQ-010 ctrl_signal_o  output  4  ALU control code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
REQ-011 op1_o, op2_o  output  64 each  ALU operands.
REQ-012 alu_result_i  input  64  combinational ALU result for the current ctrl_signal_o/op1_o/op2_o.
REQ-013 out_valid_o  output  1  writeback result valid.
REQ-014 out_ready_i  input  1  downstream accepts the result.
REQ-015 result_o  output  64  writeback value.
REQ-016 rd_o  output  5  writeback register tag.
REQ-017 illegal_o  output  1  the operation had an unsupported encoding.

Function
REQ-018 The block SHALL be a two-stage valid/ready pipeline: S1 (decode register driving the ALU) and S2 (result register driving writeback).
REQ-019 Transfers SHALL occur on in_valid_i&in_ready_o (input) and out_valid_o&out_ready_i (output).
REQ-020 The decode SHALL map as follows: alu_op 00 -> ADD; alu_op 01 -> SUB.
REQ-021 For alu_op 10, the decode SHALL map funct3 000 with f7b5=0 -> ADD, funct3 000 with f7b5=1 -> SUB, 111 -> AND, 110 -> OR, and any other funct3 -> illegal.
REQ-022 For alu_op 11, the decode SHALL map 000 -> ADD (f7b5 ignored), 111 -> AND, 110 -> OR, and any other funct3 -> illegal.
REQ-023 op1 SHALL be rs1_val_i; op2 SHALL be rs2_val_i for alu_op 01/10 and imm_i for alu_op 00/11.
REQ-024 An illegal operation SHALL be registered with ctrl 0010, and SHALL produce result_o=0 and illegal_o=1 at S2.
REQ-025 The S1 register SHALL hold ctrl_signal_o, op1_o, op2_o, rd, illegal and s1_valid, and SHALL load on input transfer.
REQ-026 S2 SHALL capture alu_result_i (or 0 if illegal), rd and illegal when S1 advances.
REQ-027 S1 SHALL advance when s1_valid & (!out_valid_o | out_ready_i).
REQ-028 in_ready_o SHALL be !s1_valid | S1-advance (combinational, no dependence on in_valid_i).
REQ-029 Latency SHALL be 2 cycles from input transfer to out_valid_o, with no back-pressure.
REQ-030 Throughput SHALL be one operation per cycle while out_ready_i=1.
REQ-031 While out_valid_o=1 and out_ready_i=0, result_o, rd_o and illegal_o SHALL hold stable, and S1 SHALL hold its contents.
REQ-032 With S1 and S2 both full, input SHALL stall and no operation SHALL be dropped or duplicated.
REQ-033 Simultaneous output transfer and S1 advance in one cycle SHALL replace S2 contents with no bubble.
REQ-034 When S1 is empty, ctrl_signal_o/op1_o/op2_o SHALL retain their last values, and alu_result_i SHALL be ignored.
REQ-035 Operations SHALL leave the block in acceptance order.

Reset
REQ-036 While rst_i=1 at a clock edge, s1_valid and out_valid_o SHALL clear.
REQ-037 While rst_i=1 at a clock edge, ctrl_signal_o, op1_o, op2_o, result_o, rd_o and illegal_o SHALL all clear to 0.
REQ-038 Reset mid-operation SHALL discard all in-flight operations, and no out_valid_o SHALL follow for them.
REQ-039 in_ready_o SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-040 R-type ADD (alu_op=10, f3=000, f7b5=0, rs1=5, rs2=7), out_ready_i=1 -> ctrl_signal_o=0010 one cycle later; out_valid_o, result_o=12, rd_o echoed two cycles after accept.
REQ-041 Back-to-back SUB (01, rs1=3, rs2=10) then I-type OR (11, f3=110, rs1=0xF0, imm=0x0F) -> results 0xFFFFFFFFFFFFFFF9 then 0xFF on consecutive cycles.
REQ-042 I-type AND, then out_ready_i=0 for 4 cycles while feeding 3 ops -> in_ready_o falls after 2 accepted, result_o stable, all 3 ops delivered in order after release.
REQ-043 R-type f3=001 -> illegal_o=1, result_o=0, ctrl_signal_o=0010.
REQ-044 rst_i asserted with both stages full -> next cycle out_valid_o=0, all outputs 0, in_ready_o=1.
